io_intc: RTL and testbench

Machine external interrupt controller on the IO bus. Collects up to `NUM_SRC` interrupt lines, with source 0 driven by the timer compare output `frc_cntr_val_leq`. Latches and masks the sources, resolves fixed priority, and drives `ext_irq` to the CSR block for mip.MEIP. Software claims and completes interrupts through bus registers. Sits in the IO read chain directly downstream of the free-run counter.

---
 rtl/io_intc_if.sv | 31 +++
 rtl/io_intc.sv | 181 ++++++++++++++++++
 tb/tb_io_intc.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_intc_if.sv
// rtl/io_intc_if.sv - IO bus and interrupt line bundle for io_intc
interface io_intc_if #(
  parameter int NUM_SRC = 8
);
  logic               dma_io_we;
  logic [15:2]        dma_io_wadr;
  logic [31:0]        dma_io_wdata;
  logic [15:2]        dma_io_radr;
  logic               dma_io_radr_en;
  logic [31:0]        dma_io_rdata_in;
  logic [31:0]        dma_io_rdata;
  logic [NUM_SRC-1:0] irq_src;
  logic               csr_meie;
  logic               ext_irq;

  // Bus/CPU side: drives strobes, addresses, upstream read data and the interrupt lines
  modport master (
    output dma_io_we, dma_io_wadr, dma_io_wdata,
    output dma_io_radr, dma_io_radr_en, dma_io_rdata_in,
    output irq_src, csr_meie,
    input  dma_io_rdata, ext_irq
  );

  // Controller side
  modport slave (
    input  dma_io_we, dma_io_wadr, dma_io_wdata,
    input  dma_io_radr, dma_io_radr_en, dma_io_rdata_in,
    input  irq_src, csr_meie,
    output dma_io_rdata, ext_irq
  );
endinterface

// File: rtl/io_intc.sv
// rtl/io_intc.sv - machine external interrupt controller on the chained IO bus
module io_intc #(
  parameter int NUM_SRC = 8
) (
  input  logic     clk,
  input  logic     rst,
  io_intc_if.slave bus
);

  localparam logic [15:2] A_PEND   = 14'h3E40;
  localparam logic [15:2] A_ENABLE = 14'h3E41;
  localparam logic [15:2] A_MODE   = 14'h3E42;
  localparam logic [15:2] A_CLAIM  = 14'h3E43;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_CLAIMED = 1'b1
  } state_t;

  // Source sampling and per-source configuration
  logic [NUM_SRC-1:0] r_src_q;
  logic [NUM_SRC-1:0] r_edge;
  logic [NUM_SRC-1:0] r_enable;
  logic [NUM_SRC-1:0] r_mode;

  // Claim/complete FSM and request output
  state_t             r_state;
  logic [4:0]         r_claim_id;
  logic               r_ext_irq;

  // Read pipeline: one flag per local register plus the captured data
  logic [3:0]         r_rd_flag;
  logic [31:0]        r_rd_data;

  // Address decode
  logic               w_wr_pend;
  logic               w_wr_enable;
  logic               w_wr_mode;
  logic               w_wr_claim;
  logic               w_rd_pend;
  logic               w_rd_enable;
  logic               w_rd_mode;
  logic               w_rd_claim;

  logic [NUM_SRC-1:0] w_wdata_src;
  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_pend;
  logic [NUM_SRC-1:0] w_active;
  logic [NUM_SRC-1:0] w_w1c;
  logic [NUM_SRC-1:0] w_claim_clr;
  logic [4:0]         w_id;
  logic [4:0]         w_claim_rd_id;
  logic               w_claim_take;
  logic               w_complete;
  logic [31:0]        w_rd_data;
  logic               w_unused_wdata;

  assign w_wr_pend   = bus.dma_io_we && (bus.dma_io_wadr == A_PEND);
  assign w_wr_enable = bus.dma_io_we && (bus.dma_io_wadr == A_ENABLE);
  assign w_wr_mode   = bus.dma_io_we && (bus.dma_io_wadr == A_MODE);
  assign w_wr_claim  = bus.dma_io_we && (bus.dma_io_wadr == A_CLAIM);

  assign w_rd_pend   = bus.dma_io_radr_en && (bus.dma_io_radr == A_PEND);
  assign w_rd_enable = bus.dma_io_radr_en && (bus.dma_io_radr == A_ENABLE);
  assign w_rd_mode   = bus.dma_io_radr_en && (bus.dma_io_radr == A_MODE);
  assign w_rd_claim  = bus.dma_io_radr_en && (bus.dma_io_radr == A_CLAIM);

  // Bits at or above NUM_SRC are simply dropped on writes
  assign w_wdata_src    = bus.dma_io_wdata[NUM_SRC-1:0];
  assign w_unused_wdata = ^bus.dma_io_wdata;

  assign w_rise   = bus.irq_src & ~r_src_q;
  assign w_pend   = (r_mode & r_edge) | (~r_mode & r_src_q);
  assign w_active = w_pend & r_enable;
  assign w_w1c    = w_wr_pend ? w_wdata_src : '0;

  // Fixed priority: lowest index wins, ID is index+1, 0 means nothing to claim
  always_comb begin
    w_id = 5'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_active[i]) w_id = 5'(i + 1);
    end
  end

  // A claim read while already CLAIMED reports 0 and has no side effect
  assign w_claim_rd_id = (r_state == S_IDLE) ? w_id : 5'd0;
  assign w_claim_take  = w_rd_claim && (r_state == S_IDLE) && (w_id != 5'd0);
  assign w_complete    = w_wr_claim && (r_state == S_CLAIMED) &&
                         (bus.dma_io_wdata[4:0] == r_claim_id);

  // Edge latch of the source being claimed is released by the claim read
  always_comb begin
    w_claim_clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_claim_clr[i] = w_claim_take && (w_id == 5'(i + 1));
    end
  end

  // Read data as seen in the radr_en cycle (pre-edge state)
  always_comb begin
    w_rd_data = 32'd0;
    if (w_rd_pend)   w_rd_data = 32'(w_pend);
    if (w_rd_enable) w_rd_data = 32'(r_enable);
    if (w_rd_mode)   w_rd_data = 32'(r_mode);
    if (w_rd_claim)  w_rd_data = 32'(w_claim_rd_id);
  end

  // Source sampling and edge latches; a new rising edge beats any clear in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_src_q <= '0;
      r_edge  <= '0;
    end else begin
      r_src_q <= bus.irq_src;
      r_edge  <= (r_edge & ~(w_w1c | w_claim_clr)) | w_rise;
    end
  end

  // Enable and mode configuration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_enable <= '0;
      r_mode   <= '0;
    end else begin
      if (w_wr_enable) r_enable <= w_wdata_src;
      if (w_wr_mode)   r_mode   <= w_wdata_src;
    end
  end

  // Claim/complete FSM; completion is checked against pre-edge state so a
  // same-cycle claim read in CLAIMED cannot re-claim
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_claim_id <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_claim_take) begin
            r_state    <= S_CLAIMED;
            r_claim_id <= w_id;
          end
        end
        S_CLAIMED: begin
          if (w_complete) begin
            r_state    <= S_IDLE;
            r_claim_id <= 5'd0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_claim_id <= 5'd0;
        end
      endcase
    end
  end

  // Registered request to the CSR block, held off while an interrupt is claimed
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ext_irq <= 1'b0;
    end else begin
      r_ext_irq <= (r_state == S_IDLE) && (|w_active) && bus.csr_meie;
    end
  end

  // One-cycle read pipeline matching the other chained IO blocks
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_flag <= 4'd0;
      r_rd_data <= 32'd0;
    end else begin
      r_rd_flag <= {w_rd_claim, w_rd_mode, w_rd_enable, w_rd_pend};
      r_rd_data <= w_rd_data;
    end
  end

  assign bus.dma_io_rdata = (|r_rd_flag) ? r_rd_data : bus.dma_io_rdata_in;
  assign bus.ext_irq      = r_ext_irq;

endmodule

// File: tb/tb_io_intc.sv
// tb/tb_io_intc.sv - directed self-checking bench for io_intc
module tb_io_intc;

  localparam logic [15:2] A_PEND   = 14'h3E40;
  localparam logic [15:2] A_ENABLE = 14'h3E41;
  localparam logic [15:2] A_MODE   = 14'h3E42;
  localparam logic [15:2] A_CLAIM  = 14'h3E43;
  localparam logic [31:0] CHAIN    = 32'hA5A5A5A5;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  io_intc_if #(.NUM_SRC(8)) bus ();

  io_intc #(.NUM_SRC(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:2] adr, input logic [31:0] data);
    bus.dma_io_we    = 1'b1;
    bus.dma_io_wadr  = adr;
    bus.dma_io_wdata = data;
    tick();
    bus.dma_io_we    = 1'b0;
  endtask

  task automatic bus_read(input logic [15:2] adr, output logic [31:0] data);
    bus.dma_io_radr_en = 1'b1;
    bus.dma_io_radr    = adr;
    tick();
    bus.dma_io_radr_en = 1'b0;
    data = bus.dma_io_rdata;
  endtask

  task automatic pulse_src(input logic [7:0] mask);
    bus.irq_src = mask;
    tick();
    bus.irq_src = 8'h00;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_tests++;
    if (bus.ext_irq !== 1'b0) begin
      $display("FAIL reset_ext_irq: got %b expected 0", bus.ext_irq); n_fail++;
    end
    n_tests++;
    if (bus.dma_io_rdata !== CHAIN) begin
      $display("FAIL reset_passthrough: got %h expected %h", bus.dma_io_rdata, CHAIN); n_fail++;
    end
    for (int a = 0; a < 4; a++) begin
      bus_read(A_PEND + 14'(a), d);
      n_tests++;
      if (d !== 32'd0) begin
        $display("FAIL reset_reg%0d: got %h expected 00000000", a, d); n_fail++;
      end
    end
    tick();
    n_tests++;
    if (bus.dma_io_rdata !== CHAIN) begin
      $display("FAIL idle_passthrough: got %h expected %h", bus.dma_io_rdata, CHAIN); n_fail++;
    end
  endtask

  task automatic test_timer_level();
    logic [31:0] d;
    bus_write(A_ENABLE, 32'h1);
    bus.csr_meie   = 1'b1;
    bus.irq_src[0] = 1'b1;
    tick();
    n_tests++;
    if (bus.ext_irq !== 1'b0) begin
      $display("FAIL level_latency1: got %b expected 0", bus.ext_irq); n_fail++;
    end
    tick();
    n_tests++;
    if (bus.ext_irq !== 1'b1) begin
      $display("FAIL level_latency2: got %b expected 1", bus.ext_irq); n_fail++;
    end
    bus_read(A_CLAIM, d);
    n_tests++;
    if (d !== 32'd1) begin
      $display("FAIL level_claim: got %h expected 00000001", d); n_fail++;
    end
    tick();
    n_tests++;
    if (bus.ext_irq !== 1'b0) begin
      $display("FAIL level_claim_drop: got %b expected 0", bus.ext_irq); n_fail++;
    end
    bus_read(A_CLAIM, d);
    n_tests++;
    if (d !== 32'd0) begin
      $display("FAIL level_claim_nested: got %h expected 00000000", d); n_fail++;
    end
    bus_write(A_CLAIM, 32'd2);
    tick();
    n_tests++;
    if (bus.ext_irq !== 1'b0) begin
      $display("FAIL level_wrong_complete: got %b expected 0", bus.ext_irq); n_fail++;
    end
    bus_write(A_CLAIM, 32'd1);
    n_tests++;
    if (bus.ext_irq !== 1'b0) begin
      $display("FAIL level_complete_edge: got %b expected 0", bus.ext_irq); n_fail++;
    end
    tick();
    n_tests++;
    if (bus.ext_irq !== 1'b1) begin
      $display("FAIL level_reassert: got %b expected 1", bus.ext_irq); n_fail++;
    end
    bus.irq_src[0] = 1'b0;
    tick();
    tick();
    n_tests++;
    if (bus.ext_irq !== 1'b0) begin
      $display("FAIL level_release: got %b expected 0", bus.ext_irq); n_fail++;
    end
  endtask

  task automatic test_edge_latch();
    logic [31:0] d;
    bus_write(A_MODE, 32'h08);
    bus_write(A_ENABLE, 32'h08);
    pulse_src(8'h08);
    bus_read(A_PEND, d);
    n_tests++;
    if (d !== 32'h08) begin
      $display("FAIL edge_pend: got %h expected 00000008", d); n_fail++;
    end
    n_tests++;
    if (bus.ext_irq !== 1'b1) begin
      $display("FAIL edge_irq: got %b expected 1", bus.ext_irq); n_fail++;
    end
    bus_read(A_CLAIM, d);
    n_tests++;
    if (d !== 32'd4) begin
      $display("FAIL edge_claim: got %h expected 00000004", d); n_fail++;
    end
    bus_read(A_PEND, d);
    n_tests++;
    if (d !== 32'h0) begin
      $display("FAIL edge_pend_after_claim: got %h expected 00000000", d); n_fail++;
    end
    bus_write(A_CLAIM, 32'd4);
    tick();
    n_tests++;
    if (bus.ext_irq !== 1'b0) begin
      $display("FAIL edge_after_complete: got %b expected 0", bus.ext_irq); n_fail++;
    end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    bus_write(A_ENABLE, 32'hFF);
    bus_write(A_MODE, 32'hFF);
    pulse_src(8'h24);
    bus_read(A_CLAIM, d);
    n_tests++;
    if (d !== 32'd3) begin
      $display("FAIL prio_first: got %h expected 00000003", d); n_fail++;
    end
    bus_write(A_CLAIM, 32'd3);
    bus_read(A_CLAIM, d);
    n_tests++;
    if (d !== 32'd6) begin
      $display("FAIL prio_second: got %h expected 00000006", d); n_fail++;
    end
    bus_write(A_CLAIM, 32'd6);
    bus_read(A_PEND, d);
    n_tests++;
    if (d !== 32'h0) begin
      $display("FAIL prio_drained: got %h expected 00000000", d); n_fail++;
    end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    bus.irq_src      = 8'h08;
    bus.dma_io_we    = 1'b1;
    bus.dma_io_wadr  = A_PEND;
    bus.dma_io_wdata = 32'h08;
    tick();
    bus.dma_io_we = 1'b0;
    bus.irq_src   = 8'h00;
    bus_read(A_PEND, d);
    n_tests++;
    if (d !== 32'h08) begin
      $display("FAIL collision_set_wins: got %h expected 00000008", d); n_fail++;
    end
    bus_write(A_PEND, 32'h08);
    bus_read(A_PEND, d);
    n_tests++;
    if (d !== 32'h0) begin
      $display("FAIL w1c_clears: got %h expected 00000000", d); n_fail++;
    end
  endtask

  task automatic test_masking();
    logic [31:0] d;
    bus.csr_meie = 1'b0;
    pulse_src(8'h02);
    tick();
    tick();
    n_tests++;
    if (bus.ext_irq !== 1'b0) begin
      $display("FAIL mask_meie: got %b expected 0", bus.ext_irq); n_fail++;
    end
    bus.csr_meie = 1'b1;
    tick();
    n_tests++;
    if (bus.ext_irq !== 1'b1) begin
      $display("FAIL mask_meie_on: got %b expected 1", bus.ext_irq); n_fail++;
    end
    bus_write(A_ENABLE, 32'h00);
    tick();
    n_tests++;
    if (bus.ext_irq !== 1'b0) begin
      $display("FAIL mask_enable_off: got %b expected 0", bus.ext_irq); n_fail++;
    end
    bus_read(A_PEND, d);
    n_tests++;
    if (d !== 32'h02) begin
      $display("FAIL mask_latch_kept: got %h expected 00000002", d); n_fail++;
    end
    bus_write(A_ENABLE, 32'hFF);
    bus.csr_meie = 1'b0;
    bus_read(A_CLAIM, d);
    n_tests++;
    if (d !== 32'd2) begin
      $display("FAIL mask_claim: got %h expected 00000002", d); n_fail++;
    end
    bus_write(A_CLAIM, 32'd2);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    bus_write(A_MODE, 32'h00);
    bus.dma_io_we      = 1'b1;
    bus.dma_io_wadr    = A_MODE;
    bus.dma_io_wdata   = 32'hFFFF_FF55;
    bus.dma_io_radr_en = 1'b1;
    bus.dma_io_radr    = A_MODE;
    tick();
    bus.dma_io_we      = 1'b0;
    bus.dma_io_radr_en = 1'b0;
    n_tests++;
    if (bus.dma_io_rdata !== 32'h0) begin
      $display("FAIL rw_same_cycle_old: got %h expected 00000000", bus.dma_io_rdata); n_fail++;
    end
    bus_read(A_MODE, d);
    n_tests++;
    if (d !== 32'h55) begin
      $display("FAIL rw_new_value_masked: got %h expected 00000055", d); n_fail++;
    end
  endtask

  task automatic test_reset_mid_claim();
    logic [31:0] d;
    bus_write(A_MODE, 32'h00);
    bus_write(A_ENABLE, 32'h01);
    bus.irq_src[0] = 1'b1;
    tick();
    bus_read(A_CLAIM, d);
    n_tests++;
    if (d !== 32'd1) begin
      $display("FAIL midrst_claim: got %h expected 00000001", d); n_fail++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus_read(A_ENABLE, d);
    n_tests++;
    if (d !== 32'h0) begin
      $display("FAIL midrst_enable: got %h expected 00000000", d); n_fail++;
    end
    bus_write(A_ENABLE, 32'h01);
    bus_read(A_CLAIM, d);
    n_tests++;
    if (d !== 32'd1) begin
      $display("FAIL midrst_fsm_idle: got %h expected 00000001", d); n_fail++;
    end
    bus.irq_src[0] = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst                 = 1'b1;
    bus.dma_io_we       = 1'b0;
    bus.dma_io_wadr     = '0;
    bus.dma_io_wdata    = '0;
    bus.dma_io_radr     = '0;
    bus.dma_io_radr_en  = 1'b0;
    bus.dma_io_rdata_in = CHAIN;
    bus.irq_src         = '0;
    bus.csr_meie        = 1'b0;
    test_reset();
    test_timer_level();
    test_edge_latch();
    test_priority();
    test_collision();
    test_masking();
    test_back_to_back();
    test_reset_mid_claim();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
